// File: rtl/fp_pool_reduce.sv
// Streaming per-lane max/min pooling over WINDOW consecutive beats of packed FP vectors.
// Any NaN in a lane's window forces that lane's result to the canonical qNaN.
module fp_pool_reduce #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned LANES  = 4,
    parameter int unsigned WINDOW = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mode,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0]     in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0]     out_data,
    output logic [LANES-1:0]                     out_nan
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Monotonic unsigned key: larger key means larger FP value, -0 below +0.
    function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
        return x[W-1] ? ~x : {1'b1, x[W-2:0]};
    endfunction

    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction

    logic [CNT_W-1:0]   cnt;
    logic               mode_q;
    logic [W-1:0]       acc     [LANES];
    logic [W-1:0]       acc_nxt [LANES];
    logic [LANES-1:0]   nan_acc;
    logic [LANES-1:0]   nan_nxt;
    logic [LANES*W-1:0] result;
    logic               last_beat;
    logic               accept;

    assign last_beat = (cnt == LAST);
    // Only the closing beat of a window must wait for a stalled result.
    assign in_ready  = !(last_beat && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        logic [W-1:0] elem;
        logic         elem_nan;
        logic         take;

        assign elem     = in_data[i*W +: W];
        assign elem_nan = is_nan(elem);
        // Strict compare: ties keep the accumulator.
        assign take     = mode_q ? (order_key(elem) < order_key(acc[i]))
                                 : (order_key(elem) > order_key(acc[i]));
        assign acc_nxt[i]        = (cnt == '0) ? elem : (take ? elem : acc[i]);
        assign nan_nxt[i]        = (cnt == '0) ? elem_nan : (nan_acc[i] | elem_nan);
        assign result[i*W +: W]  = nan_nxt[i] ? QNAN : acc_nxt[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mode_q    <= 1'b0;
            nan_acc   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_nan   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    acc[i] <= acc_nxt[i];
                end
                nan_acc <= nan_nxt;
                if (cnt == '0) begin
                    mode_q <= mode;
                end
                if (last_beat) begin
                    out_data  <= result;
                    out_nan   <= nan_nxt;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_pool_reduce.sv
// Bench for fp_pool_reduce: directed pooling cases plus random traffic against a value-level model.
module tb_fp_pool_reduce;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned LANES  = 4;
    localparam int unsigned WINDOW = 4;
    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned DW     = LANES * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [LANES-1:0] out_nan;

    fp_pool_reduce #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: pending results as {nan flags, data}, plus the window being built.
    logic [DW+LANES-1:0] exp_q[$];
    int                  m_cnt;
    logic                m_mode;
    logic [W-1:0]        m_acc [LANES];
    logic [LANES-1:0]    m_nan;
    logic [DW-1:0]       last_out;
    logic [LANES-1:0]    last_nan;
    logic                rdy;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit f_is_nan(input logic [W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    // Real-number order from sign and magnitude; -0 counts below +0.
    function automatic bit f_less(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic logic [DW-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return {r[31], 8'hFF, r[22:1], 1'b1};
            5: return {r[31], 8'h00, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input logic md);
        logic [DW-1:0] res;
        logic [31:0]   e;
        for (int i = 0; i < int'(LANES); i++) begin
            e = d[i*W +: W];
            if (m_cnt == 0) begin
                m_acc[i] = e;
                m_nan[i] = f_is_nan(e);
            end else begin
                m_nan[i] = m_nan[i] | f_is_nan(e);
                if (m_mode ? f_less(e, m_acc[i]) : f_less(m_acc[i], e)) m_acc[i] = e;
            end
        end
        if (m_cnt == 0) m_mode = md;
        if (m_cnt == int'(WINDOW) - 1) begin
            for (int i = 0; i < int'(LANES); i++)
                res[i*W +: W] = m_nan[i] ? 32'h7FC0_0000 : m_acc[i];
            exp_q.push_back({m_nan, res});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // One clock cycle: drive at negedge, check outputs 1ns later, update model for the coming edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic md, output bit accepted);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        mode      = md;
        out_ready = rdy;
        #1;
        chk("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
        exp_rdy = !((m_cnt == int'(WINDOW) - 1) && (exp_q.size() > 0) && !rdy);
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        if (exp_q.size() > 0) begin
            chk("out_beat", 256'({out_nan, out_data}), 256'(exp_q[0]));
            if (out_valid && rdy) begin
                last_out = out_data;
                last_nan = out_nan;
                void'(exp_q.pop_front());
            end
        end
        accepted = v && in_ready;
        if (accepted) model_accept(d, md);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic md);
        bit a;
        int n;
        n = 0;
        a = 0;
        while (!a && n < 50) begin
            step(1'b1, d, md, a);
            n++;
        end
        if (!a) chk("send_timeout", 256'(0), 256'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_nan", 256'(out_nan), 256'(0));
        exp_q.delete();
        m_cnt = 0;
    endtask

    initial begin
        bit a;
        logic [31:0] seq [4];
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rdy = 1'b1; m_cnt = 0; m_mode = 1'b0; m_nan = '0;
        last_out = '0; last_nan = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Max / min of the reference sequence on every lane
        seq = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'h3F00_0000};
        for (int k = 0; k < 4; k++) send(pack4(seq[k], seq[k], seq[k], seq[k]), 1'b0);
        idle(1);
        chk("max_basic", 256'(last_out[31:0]), 256'(32'h4040_0000));
        for (int k = 0; k < 4; k++) send(pack4(seq[k], seq[k], seq[k], seq[k]), 1'b1);
        idle(1);
        chk("min_basic", 256'(last_out[127:96]), 256'(32'hC000_0000));

        // Signed zero (max) in lane 0, infinities (min) in lane 1; mode held per window
        send(pack4(32'h8000_0000, 32'h7F80_0000, 0, 0), 1'b0);
        send(pack4(32'h0000_0000, 32'hFF80_0000, 0, 0), 1'b1);
        send(pack4(32'h8000_0000, 32'h0, 0, 0), 1'b1);
        send(pack4(32'h8000_0000, 32'h0, 0, 0), 1'b1);
        idle(1);
        chk("max_signed_zero", 256'(last_out[31:0]), 256'(32'h0000_0000));
        send(pack4(32'h8000_0000, 32'h7F80_0000, 0, 0), 1'b1);
        send(pack4(32'h0000_0000, 32'hFF80_0000, 0, 0), 1'b0);
        send(pack4(32'h8000_0000, 32'h0, 0, 0), 1'b0);
        send(pack4(32'h8000_0000, 32'h0, 0, 0), 1'b0);
        idle(1);
        chk("min_inf", 256'(last_out[63:32]), 256'(32'hFF80_0000));
        chk("min_signed_zero", 256'(last_out[31:0]), 256'(32'h8000_0000));

        // NaN on lane 2, beat 1
        send(pack4(32'h3F80_0000, 32'h1, 32'h4000_0000, 32'hBF80_0000), 1'b0);
        send(pack4(32'h4000_0000, 32'h2, 32'h7F80_0001, 32'hC000_0000), 1'b0);
        send(pack4(32'h3F00_0000, 32'h0, 32'h3F80_0000, 32'hC040_0000), 1'b0);
        send(pack4(32'h0000_0000, 32'h8000_0000, 32'h0, 32'hC080_0000), 1'b0);
        idle(1);
        chk("nan_lane2", 256'(last_out[95:64]), 256'(32'h7FC0_0000));
        chk("nan_flags", 256'(last_nan), 256'(4'b0100));
        chk("nan_lane0", 256'(last_out[31:0]), 256'(32'h4000_0000));
        chk("nan_lane3", 256'(last_out[127:96]), 256'(32'hBF80_0000));

        // Backpressure: window 1 waits while window 2 builds; only window 2's last beat stalls
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(pack4(32'h3F80_0000 + 32'(k), rand_elem(), rand_elem(), rand_elem()), 1'b0);
        for (int k = 0; k < 3; k++) send(pack4(32'h4080_0000 + 32'(k), rand_elem(), rand_elem(), rand_elem()), 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, pack4(32'h4100_0000, 0, 0, 0), 1'b1, a);
            chk("bp_stall", 256'(a), 256'(0));
            chk("bp_hold", 256'(out_data[31:0]), 256'(32'h3F80_0003));
        end
        rdy = 1'b1;
        send(pack4(32'h4100_0000, 0, 0, 0), 1'b1);
        chk("bp_first_out", 256'(last_out[31:0]), 256'(32'h3F80_0003));
        idle(1);
        chk("bp_second_out", 256'(last_out[31:0]), 256'(32'h4080_0000));
        chk("bp_drained", 256'(exp_q.size()), 256'(0));

        // Reset mid-window with a result pending
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) send(pack4(32'h4700_0000, 32'h4700_0000, 32'h4700_0000, 32'h4700_0000), 1'b0);
        do_reset();
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) send(pack4(32'h3F80_0000 + 32'(k), 32'hBF80_0000, 0, 32'h8000_0000), 1'b0);
        idle(1);
        chk("post_rst_lane0", 256'(last_out[31:0]), 256'(32'h3F80_0003));
        chk("post_rst_lane1", 256'(last_out[63:32]), 256'(32'hBF80_0000));

        // Random traffic, random backpressure and mode
        for (int k = 0; k < 600; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 3) != 0), pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem()),
                 1'($urandom_range(0, 1)), a);
        end
        rdy = 1'b1;
        idle(3);
        chk("final_drain", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_pool_reduce.md
Name: fp_pool_reduce

Overview:
- Streaming, parametrised successor to the combinational FP32 max comparator.
- Reduces consecutive groups of WINDOW floating-point vectors, each LANES lanes wide, to one vector per group.
- Each output lane holds the per-lane max or min of that lane across the group.
- Sits between the systolic array output and the activation/writeback stage; implements max/min pooling with valid/ready flow control on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width. Element width W = 1+EXP_W+MAN_W.
- LANES, 4, number of independent lanes per beat.
- WINDOW, 4, input beats reduced per output beat. Must be at least 1.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = max, 1 = min. Sampled on the first beat of a window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LANES*W  lane i at bits [i*W +: W].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*W  reduced result, same lane packing as in_data.
- out_nan  out  LANES  per lane, 1 if any input to that lane in the window was NaN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: out_valid=0, out_data=0, out_nan=0, beat counter=0, accumulators=0, latched mode=0.
- Reset mid-window discards the partial accumulation and any pending output.
- A beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
- Ordering key per element:
  - sign=0: key = bits with MSB inverted.
  - sign=1: key = bitwise NOT of bits.
  - Compare keys unsigned. Result: -0 < +0; subnormals ordered correctly; infinities are extremes.
  - No normalisation or exponent arithmetic is performed; the result is always bit-exact equal to one input element.
- NaN (exponent all ones, mantissa != 0):
  - Sets that lane's sticky NaN flag.
  - The lane's output is the canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0) and out_nan[i]=1, regardless of mode.
- Counter cnt runs 0..WINDOW-1.
  - cnt==0 beat: accumulator loads the element, NaN flag loads the element's NaN bit, mode is latched.
  - Later beats: accumulator = better of (accumulator, element) per the latched mode. Ties keep the accumulator; bits are identical except -0/+0, which the key order resolves.
- On acceptance with cnt==WINDOW-1:
  - The final result (including this beat) registers into out_data/out_nan.
  - out_valid=1 on the next cycle, so latency is 1 cycle after the last beat.
  - cnt wraps to 0.
- WINDOW=1: every accepted beat produces a result 1 cycle later. The result is the input, or qNaN if the input is NaN.
- Backpressure:
  - in_ready = !(cnt==WINDOW-1 && out_valid && !out_ready).
  - The next window accumulates while a result waits; only its final beat stalls.
  - Simultaneous result drain and last-beat acceptance in the same cycle is legal; out_valid stays 1 with the new data.
- out_data is held stable while out_valid && !out_ready.
- out_valid drops the cycle after a transfer unless a new result is loaded in that same cycle.
- mode changes mid-window have no effect until the next window's first beat.

Test Plan:
- Max, LANES=1, WINDOW=4:
  - Stimulus: 0x3F800000 (1.0), 0xC0000000 (-2.0), 0x40400000 (3.0), 0x3F000000 (0.5), out_ready=1.
  - Required: out_data=0x40400000, out_valid exactly 1 cycle after the 4th beat.
- Min, same inputs -> out_data=0xC0000000.
- Signed zero and infinity:
  - Max of {0x80000000, 0x00000000, 0x80000000, 0x80000000} -> 0x00000000.
  - Min of {0x7F800000, 0xFF800000, 0, 0} -> 0xFF800000.
- NaN: lane 2 receives 0x7F800001 on beat 1, max mode -> lane 2 = 0x7FC00000, out_nan=4'b0100, other lanes hold correct maxima.
- Backpressure:
  - Hold out_ready=0 after window 1 completes; stream window 2 back-to-back.
  - Required: in_ready drops only while window 2's 4th beat is offered; out_data stays window 1's value.
  - Raising out_ready gives window 1, then window 2 one cycle later, with no lost or duplicated beat.
- Reset mid-window:
  - Assert rst after 2 beats.
  - Required: out_valid=0 next cycle; the following 4 beats form a fresh window whose result ignores the pre-reset beats.
